mips_mem_responder: RTL and testbench

- Word-addressed 32-bit memory that services load/store/fetch requests from the MIPS32 core pipeline, or from any other initiator.
- Requests arrive over a valid/ready request channel. Results return over a valid/ready response channel after a programmable number of wait states.
- It is the responder end of the core's memory interface. It lets the core run against realistic memory latency instead of a zero-delay array.

---
 rtl/mips_mem_responder.sv | 149 ++++++++++++++
 tb/tb_mips_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// ============================================================================
// Module   : mips_mem_responder
// Brief    : Word-addressed memory responder with valid/ready channels and
//            programmable wait states for the MIPS32 memory interface.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    generate
        if (LATENCY < 0 || LATENCY > 15) begin : g_latency_check
            $error("mips_mem_responder: LATENCY must be in 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam bit       c_zero_lat = (LATENCY == 0);
    localparam logic [3:0] c_cnt_load = c_zero_lat ? 4'd0 : 4'(LATENCY - 1);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_busy;
    logic [DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

    logic                w_accept;
    logic                w_access;
    logic                w_acc_we;
    logic [31:0]         w_acc_addr;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic                w_in_range;
    logic                w_mem_we;
    logic [DATA_W-1:0]   w_rd_data;

    // With zero latency the access happens on the accept edge, so the
    // request fields are used directly instead of the captured copies.
    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign w_access    = (w_accept && c_zero_lat) || ((r_state == S_WAIT) && (r_cnt == 4'd0));
    assign w_acc_we    = c_zero_lat ? req_we    : r_we;
    assign w_acc_addr  = c_zero_lat ? req_addr  : r_addr;
    assign w_acc_wdata = c_zero_lat ? req_wdata : r_wdata;
    assign w_in_range  = (w_acc_addr[31:ADDR_W] == '0);
    assign w_mem_we    = w_access && w_acc_we && w_in_range;
    assign w_rd_data   = r_mem[w_acc_addr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_acc_addr[ADDR_W-1:0]] <= w_acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= c_cnt_load;
                        r_state     <= S_WAIT;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase

            // The access edge overrides the IDLE/WAIT transitions above.
            if (w_access) begin
                r_state     <= S_RESP;
                r_req_ready <= 1'b0;
                r_busy      <= 1'b1;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= ~w_in_range;
                r_rsp_rdata <= (w_in_range && !w_acc_we) ? w_rd_data : '0;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_responder.sv
// ============================================================================
// Module   : tb_mips_mem_responder
// Brief    : Self-checking bench for mips_mem_responder at LATENCY 2, 4 and 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mips_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] mdl [3][32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 0);
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_dut
        mips_mem_responder #(
            .ADDR_W (10),
            .DATA_W (32),
            .LATENCY((i == 0) ? 2 : ((i == 1) ? 4 : 0))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_valid(req_valid[i]),
            .req_ready(req_ready[i]),
            .req_we   (req_we[i]),
            .req_addr (req_addr[i]),
            .req_wdata(req_wdata[i]),
            .rsp_valid(rsp_valid[i]),
            .rsp_ready(rsp_ready[i]),
            .rsp_rdata(rsp_rdata[i]),
            .rsp_err  (rsp_err[i]),
            .busy     (busy[i])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request and return just after the accept edge.
    task automatic issue(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    // Full transaction against the reference model: latency, data, hold, handshake.
    task automatic txn(input int d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
        int          n;
        bit          exp_err;
        logic [31:0] exp_rd;
        exp_err = (addr >= 32'h400);
        exp_rd  = (exp_err || we) ? 32'd0 : mdl[d][addr[4:0]];
        if (!exp_err && we) mdl[d][addr[4:0]] = wdata;
        issue(d, we, addr, wdata);
        n = 0;
        while (!rsp_valid[d] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(lat_of(d)));
        check("rsp_rdata", rsp_rdata[d], exp_rd);
        check("rsp_err", 32'(rsp_err[d]), 32'(exp_err));
        check("req_ready_in_resp", 32'(req_ready[d]), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid[d]), 32'd1);
            check("hold_rdata", rsp_rdata[d], exp_rd);
            check("hold_err", 32'(rsp_err[d]), 32'(exp_err));
            check("hold_ready", 32'(req_ready[d]), 32'd0);
        end
        if (d != 2) rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        if (d != 2) rsp_ready[d] = 1'b0;
        check("post_hs_valid", 32'(rsp_valid[d]), 32'd0);
        check("post_hs_rdata", rsp_rdata[d], 32'd0);
        check("post_hs_err", 32'(rsp_err[d]), 32'd0);
        check("post_hs_ready", 32'(req_ready[d]), 32'd1);
        check("post_hs_busy", 32'(busy[d]), 32'd0);
    endtask

    initial begin
        int          t;
        int          tprev;
        int          n;
        logic [31:0] a;

        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
            rsp_ready[i] = (i == 2);
        end
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            check("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check("reset_rsp_rdata", rsp_rdata[i], 32'd0);
            check("reset_rsp_err", 32'(rsp_err[i]), 32'd0);
            check("reset_busy", 32'(busy[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check("reset_req_ready", 32'(req_ready[i]), 32'd1);

        // Directed store/load at LATENCY=2, then backpressure on the load.
        txn(0, 1'b1, 32'd5, 32'hDEADBEEF, 0);
        txn(0, 1'b0, 32'd5, 32'd0, 0);
        txn(0, 1'b0, 32'd5, 32'd0, 5);

        // Out of range must not alias onto address 0.
        txn(0, 1'b1, 32'd0, 32'h0BADF00D, 0);
        txn(0, 1'b1, 32'h400, 32'h1234, 0);
        txn(0, 1'b0, 32'd0, 32'd0, 0);
        txn(0, 1'b0, 32'h8000_0000, 32'd0, 1);

        // Reset while a response is pending.
        issue(0, 1'b0, 32'd5, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_resp_valid", 32'(rsp_valid[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("async_reset_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_reset_req_ready", 32'(req_ready[0]), 32'd1);

        // Reset mid-WAIT discards the pending write at LATENCY=4.
        txn(1, 1'b1, 32'd7, 32'h11, 0);
        issue(1, 1'b1, 32'd7, 32'hAAAA5555);
        check("wait_busy", 32'(busy[1]), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("wait_reset_busy", 32'(busy[1]), 32'd0);
        check("wait_reset_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_late_response", 32'(rsp_valid[1]), 32'd0);
        txn(1, 1'b0, 32'd7, 32'd0, 0);

        // Seed and then randomly exercise the LATENCY=2 instance.
        for (int k = 0; k < 32; k++) txn(0, 1'b1, 32'(k), $urandom, 0);
        for (int k = 0; k < 40; k++) begin
            a = ($urandom_range(0, 9) == 0) ? (32'h400 | $urandom) : 32'($urandom_range(0, 31));
            txn(0, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
        end

        // LATENCY=0 with rsp_ready tied high: back-to-back reads.
        for (int k = 0; k < 8; k++) txn(2, 1'b1, 32'(k), $urandom, 0);
        tprev = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n = 0;
            while (!req_ready[2] && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("b2b_ready_in_time", 32'(n < 10), 32'd1);
            req_valid[2] = 1'b1;
            req_we[2]    = 1'b0;
            req_addr[2]  = 32'(k);
            t = cyc;
            @(posedge clk);
            #1;
            check("b2b_rsp_valid", 32'(rsp_valid[2]), 32'd1);
            check("b2b_rdata", rsp_rdata[2], mdl[2][k]);
            if (k > 0) check("b2b_period", 32'(t - tprev), 32'd2);
            tprev = t;
        end
        @(negedge clk);
        req_valid[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_idle_after", 32'(busy[2]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
